// File: rtl/mult_secuencial_ctrl_if.sv
// Handshake and data bundle between the top-level control (master)
// and the sequential multiplier (slave).
interface mult_secuencial_ctrl_if #(
    parameter int ANCHO = 8
);
    logic                 start;
    logic                 signo;
    logic [ANCHO-1:0]     Multiplicando;
    logic [ANCHO-1:0]     Multiplicador;
    logic [2*ANCHO-1:0]   Producto;
    logic                 busy;
    logic                 done;

    modport master (
        output start, signo, Multiplicando, Multiplicador,
        input  Producto, busy, done
    );

    modport slave (
        input  start, signo, Multiplicando, Multiplicador,
        output Producto, busy, done
    );
endinterface

// File: rtl/mult_secuencial_ctrl.sv
// Sequential shift-add / radix-2 Booth multiplier with built-in controller.
// One iteration (add then shift) per clock; ANCHO iterations per product.
module mult_secuencial_ctrl #(
    parameter int ANCHO = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    mult_secuencial_ctrl_if.slave bus
);
    localparam int PW = $clog2(ANCHO + 1);

    typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [ANCHO:0]       a_q, a_d;
    logic [ANCHO:0]       m_q, m_d;
    logic [ANCHO-1:0]     q_q, q_d;
    logic                 q1_q, q1_d;
    logic                 signo_q, signo_d;
    logic [PW-1:0]        p_q, p_d;
    logic [2*ANCHO-1:0]   prod_q, prod_d;
    logic                 done_q, done_d;

    logic [ANCHO:0]       a_sum;
    logic                 last_iter;

    assign last_iter = (p_q == PW'(1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept a request in IDLE, return after the last iteration
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CALC;
            CALC:    if (last_iter) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: busy spans exactly the iteration cycles
    always_comb begin
        bus.busy = (state_q == CALC);
    end

    assign bus.done     = done_q;
    assign bus.Producto = prod_q;

    // Datapath next values: operand load in IDLE, add-and-shift in CALC
    always_comb begin
        a_d     = a_q;
        m_d     = m_q;
        q_d     = q_q;
        q1_d    = q1_q;
        signo_d = signo_q;
        p_d     = p_q;
        prod_d  = prod_q;
        done_d  = 1'b0;
        a_sum   = a_q;

        if (state_q == IDLE) begin
            if (bus.start) begin
                a_d     = '0;
                q_d     = bus.Multiplicador;
                q1_d    = 1'b0;
                p_d     = PW'(ANCHO);
                signo_d = bus.signo;
                // Extra top bit keeps -2^(ANCHO-1) operands from overflowing
                m_d     = bus.signo ? {bus.Multiplicando[ANCHO-1], bus.Multiplicando}
                                    : {1'b0, bus.Multiplicando};
            end
        end else begin
            if (signo_q) begin
                case ({q_q[0], q1_q})
                    2'b01:   a_sum = a_q + m_q;
                    2'b10:   a_sum = a_q - m_q;
                    default: a_sum = a_q;
                endcase
            end else if (q_q[0]) begin
                a_sum = a_q + m_q;
            end

            // Arithmetic shift in signed mode, logical (carry kept) in unsigned mode
            a_d  = {signo_q & a_sum[ANCHO], a_sum[ANCHO:1]};
            q_d  = {a_sum[0], q_q[ANCHO-1:1]};
            q1_d = q_q[0];
            p_d  = p_q - PW'(1);

            if (last_iter) begin
                prod_d = {a_d[ANCHO-1:0], q_d};
                done_d = 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            m_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            signo_q <= 1'b0;
            p_q     <= '0;
            prod_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            m_q     <= m_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            signo_q <= signo_d;
            p_q     <= p_d;
            prod_q  <= prod_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_mult_secuencial_ctrl.sv
// Self-checking bench: arithmetic reference model checked every cycle,
// plus directed operations with hand-computed products.
module tb_mult_secuencial_ctrl;
    localparam int ANCHO = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mult_secuencial_ctrl_if #(.ANCHO(ANCHO)) bus ();

    mult_secuencial_ctrl #(.ANCHO(ANCHO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*ANCHO-1:0] ref_mult(input logic s, input logic [ANCHO-1:0] m,
                                                   input logic [ANCHO-1:0] q);
        longint a, b, r;
        if (s) begin
            a = longint'($signed(m));
            b = longint'($signed(q));
        end else begin
            a = longint'(m);
            b = longint'(q);
        end
        r = a * b;
        return r[2*ANCHO-1:0];
    endfunction

    // Reference model: one operation in flight, result appears ANCHO edges after acceptance
    logic               act_m  = 1'b0;
    int                 cnt_m  = 0;
    logic [2*ANCHO-1:0] res_m  = '0;
    logic [2*ANCHO-1:0] prod_m = '0;
    logic               done_m = 1'b0;
    int                 dones_m = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            act_m  <= 1'b0;
            cnt_m  <= 0;
            res_m  <= '0;
            prod_m <= '0;
            done_m <= 1'b0;
        end else begin
            done_m <= 1'b0;
            if (act_m) begin
                cnt_m <= cnt_m - 1;
                if (cnt_m == 1) begin
                    act_m   <= 1'b0;
                    prod_m  <= res_m;
                    done_m  <= 1'b1;
                    dones_m <= dones_m + 1;
                end
            end else if (bus.start) begin
                act_m <= 1'b1;
                cnt_m <= ANCHO;
                res_m <= ref_mult(bus.signo, bus.Multiplicando, bus.Multiplicador);
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        chk("busy", bus.busy, act_m);
        chk("done", bus.done, done_m);
        chk("Producto", bus.Producto, prod_m);
        chk("busy_and_done", bus.busy & bus.done, 1'b0);
    end

    task automatic run_op(input string name, input logic s, input logic [ANCHO-1:0] m,
                          input logic [ANCHO-1:0] q, input logic [2*ANCHO-1:0] exp);
        int edges;
        @(negedge clk);
        bus.start = 1'b1; bus.signo = s; bus.Multiplicando = m; bus.Multiplicador = q;
        @(negedge clk);
        bus.start = 1'b0;
        bus.Multiplicando = ANCHO'($urandom);
        bus.Multiplicador = ANCHO'($urandom);
        chk({name, "_busy"}, bus.busy, 1'b1);
        edges = 0;
        while (bus.done !== 1'b1 && edges < ANCHO + 4) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        chk({name, "_latency"}, edges, ANCHO);
        chk({name, "_prod"}, bus.Producto, exp);
        $display("op %s signo=%0d M=%02h Q=%02h -> Producto=%04h after %0d edges",
                 name, s, m, q, bus.Producto, edges);
    endtask

    initial begin
        int dones;
        int n;
        int d0;
        bus.start = 1'b0; bus.signo = 1'b0;
        bus.Multiplicando = '0; bus.Multiplicador = '0;
        #1 rst = 1'b1;
        #11;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_prod", bus.Producto, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        run_op("u_d7x17", 1'b0, 8'hD7, 8'h17, 16'h1351);
        run_op("s_d7x17", 1'b1, 8'hD7, 8'h17, 16'hFC51);
        run_op("s_80x80", 1'b1, 8'h80, 8'h80, 16'h4000);
        run_op("u_ffxff", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
        run_op("u_00xa5", 1'b0, 8'h00, 8'hA5, 16'h0000);
        run_op("s_ffx01", 1'b1, 8'hFF, 8'h01, 16'hFFFF);

        // Request during an operation must be ignored
        @(negedge clk);
        bus.start = 1'b1; bus.signo = 1'b0; bus.Multiplicando = 8'h03; bus.Multiplicador = 8'h05;
        dones = 0;
        for (int c = 1; c <= ANCHO + 6; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            if (c == 3) begin
                bus.start = 1'b1; bus.signo = 1'b1;
                bus.Multiplicando = 8'hFF; bus.Multiplicador = 8'hFF;
            end
            if (c == 4) bus.start = 1'b0;
            if (bus.done === 1'b1) dones++;
        end
        chk("ignore_done_count", dones, 1);
        chk("ignore_prod", bus.Producto, 16'h000F);
        $display("op ignore_mid_start 03x05 -> Producto=%04h dones=%0d", bus.Producto, dones);

        // Asynchronous reset in the middle of iteration 4
        @(negedge clk);
        bus.start = 1'b1; bus.signo = 1'b0; bus.Multiplicando = 8'h33; bus.Multiplicador = 8'h44;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_busy", bus.busy, 1'b0);
        chk("async_rst_done", bus.done, 1'b0);
        chk("async_rst_prod", bus.Producto, 16'h0000);
        $display("op async_reset mid-operation -> busy=%0d Producto=%04h", bus.busy, bus.Producto);
        @(negedge clk);
        rst = 1'b0;
        run_op("u_0ax0b", 1'b0, 8'h0A, 8'h0B, 16'h006E);

        // Back-to-back: new request during the done cycle
        @(negedge clk);
        bus.start = 1'b1; bus.signo = 1'b0; bus.Multiplicando = 8'h12; bus.Multiplicador = 8'h34;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.done !== 1'b1 && n < ANCHO + 4) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_first_prod", bus.Producto, 16'h03A8);
        bus.start = 1'b1; bus.Multiplicando = 8'h02; bus.Multiplicador = 8'h03;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) bus.start = 1'b0;
        end while (bus.done !== 1'b1 && n < 20);
        chk("b2b_spacing", n, ANCHO + 1);
        chk("b2b_second_prod", bus.Producto, 16'h0006);
        $display("op back_to_back 12x34 then 02x03 -> Producto=%04h spacing=%0d", bus.Producto, n);

        // Randomised traffic, occasional asynchronous reset
        d0 = dones_m;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            bus.start         = ($urandom_range(0, 3) == 0);
            bus.signo         = 1'($urandom);
            bus.Multiplicando = ANCHO'($urandom);
            bus.Multiplicador = ANCHO'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
                $display("op random async reset at %0t", $time);
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        chk("random_activity", (dones_m - d0) > 50, 1'b1);
        $display("op random phase completed %0d products", dones_m - d0);
        repeat (ANCHO + 3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_secuencial_ctrl.md
Name: mult_secuencial_ctrl

Overview:
Parametrised sequential shift-add multiplier with its controller FSM built in. The external Load/Shift/Add/Decr sequencing of the current datapath is replaced by a start/busy/done handshake, and each iteration completes its add and shift in a single cycle. A runtime mode selects unsigned (shift-add) or two's-complement signed (radix-2 Booth) multiplication. It sits between the top-level control and the result register bank.

Parameters:
ANCHO, 8, operand width in bits (minimum 2); the product is 2*ANCHO bits.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
signo  input  1  mode, sampled with start: 0 = unsigned, 1 = signed two's complement
Multiplicando  input  ANCHO  operand M, sampled with start
Multiplicador  input  ANCHO  operand Q, sampled with start
Producto  output  2*ANCHO  result register, held until the next completion
busy  output  1  high while an operation is in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, any time including mid-operation): state=IDLE, busy=0, done=0, Producto=0, internal A/Q/M/Q_1/P=0. Any operation in flight is discarded.
- Internal registers: A (ANCHO+1 bits), Q (ANCHO bits), M (ANCHO+1 bits), Q_1 (1 bit), mode bit, counter P ($clog2(ANCHO+1) bits).
- States: IDLE and CALC.
- IDLE, start=1 at edge k:
  - A=0, Q=Multiplicador, Q_1=0, P=ANCHO, latch signo.
  - M=Multiplicando, sign-extended when signo=1, zero-extended when signo=0.
  - Go to CALC; busy=1 from edge k.
- IDLE, start=0: hold.
- CALC, one iteration per edge (edges k+1..k+ANCHO), add and shift in the same cycle, P=P-1:
  - Unsigned: if Q[0]=1 then A=A+M (A[ANCHO] captures the carry). Then logical right shift of {A,Q} by 1; 0 enters A[ANCHO].
  - Signed: (Q[0],Q_1)=01 → A=A+M; 10 → A=A-M; 00/11 → no change. Then arithmetic right shift of {A,Q,Q_1} by 1, replicating A[ANCHO].
  - All arithmetic is ANCHO+1 bits wide, so -2^(ANCHO-1) operands cannot overflow.
- Last iteration (P==1 before the edge, i.e. edge k+ANCHO):
  - Producto={A[ANCHO-1:0],Q} using the post-shift values.
  - done=1 for exactly one cycle; busy=0; state=IDLE.
- Latency: done is high in the cycle following edge k+ANCHO. Throughput is one result per ANCHO+1 cycles.
- Once in CALC, start, signo and the operand inputs are ignored until return to IDLE. Operand changes mid-operation have no effect.
- start=1 during the done cycle is accepted (state is IDLE), so back-to-back operation is legal. done still pulses only once per operation.
- Producto changes only at a completion edge or on reset; it keeps its value after done falls.
- busy and done are never high simultaneously.

Test Plan:
- ANCHO=8, signo=0, M=0xD7, Q=0x17, 1-cycle start pulse → busy high 8 cycles; done 1 cycle later (8 edges after the start edge); Producto=0x1351.
- signo=1, M=0xD7 (-41), Q=0x17 (23) → Producto=0xFC51 (-943); then M=0x80, Q=0x80 → Producto=0x4000.
- signo=0, M=0xFF, Q=0xFF → 0xFE01; signo=0, M=0x00, Q=0xA5 → 0x0000; signo=1, M=0xFF, Q=0x01 → 0xFFFF.
- Start 0x03*0x05; at iteration 3 pulse start with M=0xFF, Q=0xFF and toggle signo → ignored; one done only; Producto=0x000F.
- Assert rst asynchronously between clock edges at iteration 4 → busy, done and Producto go to 0 immediately. After release, 0x0A*0x0B unsigned → 0x006E.
- Start 0x12*0x34 unsigned; assert start with 0x02*0x03 in the done cycle → first done shows 0x03A8, second done exactly 9 cycles later shows 0x0006.
